// File: rtl/muxpga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muxpga_pkg
// Brief    : Shared command encoding, select encoding and LUT constants for
//            the mux-FPGA cell array.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package muxpga_pkg;

    // Array command, sampled every clock while the array is not busy
    typedef enum logic [1:0] {
        CMD_SHIFT = 2'd0,
        CMD_STEP  = 2'd1,
        CMD_RUN   = 2'd2,
        CMD_HOLD  = 2'd3
    } cmd_e;

    // Width of one configuration chain entry
    localparam int CFG_W = 4;

    // Neighbour select encoding used by both cell input muxes
    localparam logic [1:0] SEL_N = 2'd0;
    localparam logic [1:0] SEL_S = 2'd1;
    localparam logic [1:0] SEL_W = 2'd2;
    localparam logic [1:0] SEL_E = 2'd3;

    // Common LUT programs, indexed by {in1, in2}
    localparam logic [CFG_W-1:0] LUT_OR    = 4'hE;
    localparam logic [CFG_W-1:0] LUT_AND   = 4'h8;
    localparam logic [CFG_W-1:0] LUT_XOR   = 4'h6;
    localparam logic [CFG_W-1:0] LUT_PASS1 = 4'hC;
    localparam logic [CFG_W-1:0] LUT_PASS2 = 4'hA;

    // Evaluate a two-input LUT for one bit slice; in1 is the high index bit
    function automatic logic lut_bit(input logic [CFG_W-1:0] lut,
                                     input logic             in1,
                                     input logic             in2);
        return lut[{in1, in2}];
    endfunction

endpackage : muxpga_pkg
`default_nettype wire

// File: rtl/muxpga_if.sv
`default_nettype none
// ============================================================================
// Module   : muxpga_if
// Brief    : Pin-level bus of the mux-FPGA array (din/cmd in, dout/busy out).
// Revision : 1.0 - initial parametrised release
// ============================================================================
interface muxpga_if
    import muxpga_pkg::*;
#(
    parameter int W = 4
) ();

    logic [W-1:0]   din;
    cmd_e           cmd;
    logic [2*W-1:0] dout;
    logic           busy;

    // Driver side (pin wrapper / testbench)
    modport master (
        output din,
        output cmd,
        input  dout,
        input  busy
    );

    // Array side
    modport slave (
        input  din,
        input  cmd,
        output dout,
        output busy
    );

endinterface : muxpga_if
`default_nettype wire

// File: rtl/muxpga_cell.sv
`default_nettype none
// ============================================================================
// Module   : muxpga_cell
// Brief    : One W-bit array cell: two 4:1 neighbour muxes feeding a bitwise
//            two-input LUT, result captured in an enabled q register.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module muxpga_cell
    import muxpga_pkg::*;
#(
    parameter int W = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_en,
    input  wire logic [W-1:0]     i_north,
    input  wire logic [W-1:0]     i_south,
    input  wire logic [W-1:0]     i_west,
    input  wire logic [W-1:0]     i_east,
    input  wire logic [CFG_W-1:0] i_mux_cfg,
    input  wire logic [CFG_W-1:0] i_lut_cfg,
    output logic      [W-1:0]     o_q
);

    logic [1:0]   w_sel1;
    logic [1:0]   w_sel2;
    logic [W-1:0] w_in1;
    logic [W-1:0] w_in2;
    logic [W-1:0] w_f;
    logic [W-1:0] r_q;

    // Mux nibble layout is {sel2, sel1}
    assign w_sel1 = i_mux_cfg[1:0];
    assign w_sel2 = i_mux_cfg[3:2];

    // First input mux: pick the neighbour addressed by sel1
    always_comb begin
        w_in1 = i_north;
        case (w_sel1)
            SEL_N:   w_in1 = i_north;
            SEL_S:   w_in1 = i_south;
            SEL_W:   w_in1 = i_west;
            SEL_E:   w_in1 = i_east;
            default: w_in1 = i_north;
        endcase
    end

    // Second input mux: pick the neighbour addressed by sel2
    always_comb begin
        w_in2 = i_north;
        case (w_sel2)
            SEL_N:   w_in2 = i_north;
            SEL_S:   w_in2 = i_south;
            SEL_W:   w_in2 = i_west;
            SEL_E:   w_in2 = i_east;
            default: w_in2 = i_north;
        endcase
    end

    // Apply the same LUT independently to every bit slice
    always_comb begin
        w_f = '0;
        for (int b = 0; b < W; b++) begin
            w_f[b] = lut_bit(i_lut_cfg, w_in1[b], w_in2[b]);
        end
    end

    // Cell state: cleared by reset, updated only on stepping cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= w_f;
        end
    end

    assign o_q = r_q;

endmodule : muxpga_cell
`default_nettype wire

// File: rtl/muxpga_array.sv
`default_nettype none
// ============================================================================
// Module   : muxpga_array
// Brief    : ROWS x COLS array of mux/LUT cells with a nibble-wide config
//            shift chain, single-step and counted free-run modes, and a
//            status/readback output mux.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module muxpga_array
    import muxpga_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 3,
    parameter int W    = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    muxpga_if.slave   bus
);

    localparam int             c_CHAIN_LEN = 2 * ROWS * COLS;
    localparam int             c_CNT_W     = $clog2(c_CHAIN_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_CHAIN_LEN);
    localparam logic [W-1:0]   c_RUN_LAST  = {{(W-1){1'b0}}, 1'b1};

    logic [CFG_W-1:0]   r_chain [c_CHAIN_LEN];
    logic [c_CNT_W-1:0] r_shift_cnt;
    logic [W-1:0]       r_run_cnt;
    logic               r_busy;

    logic               w_cfg_loaded;
    logic               w_shift_en;
    logic               w_step_en;
    logic               w_run_start;
    logic [W-1:0]       w_q [ROWS][COLS];

    // Commands are only honoured while idle; a RUN owns the array until done
    assign w_shift_en   = !r_busy && (bus.cmd == CMD_SHIFT);
    assign w_run_start  = !r_busy && (bus.cmd == CMD_RUN);
    assign w_step_en    = r_busy || (bus.cmd == CMD_STEP);
    assign w_cfg_loaded = (r_shift_cnt == c_CNT_FULL);

    // Config shift chain: new nibble enters at entry 0, oldest sits at the end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_CHAIN_LEN; i++) begin
                r_chain[i] <= '0;
            end
        end else if (w_shift_en) begin
            r_chain[0] <= bus.din[CFG_W-1:0];
            for (int i = 1; i < c_CHAIN_LEN; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    // Count accepted shifts, saturating once the whole chain has been filled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift_cnt <= '0;
        end else if (w_shift_en && (r_shift_cnt != c_CNT_FULL)) begin
            r_shift_cnt <= r_shift_cnt + 1'b1;
        end
    end

    // Free-run control: the RUN edge only loads the count, stepping starts next
    always_ff @(posedge clk) begin
        if (reset) begin
            r_run_cnt <= '0;
            r_busy    <= 1'b0;
        end else if (r_busy) begin
            r_run_cnt <= r_run_cnt - 1'b1;
            if (r_run_cnt == c_RUN_LAST) begin
                r_busy <= 1'b0;
            end
        end else if (w_run_start) begin
            r_run_cnt <= bus.din;
            r_busy    <= (bus.din != '0);
        end
    end

    // Cell grid with torus wrap east/west; din feeds the top and bottom edges
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int c_K    = r * COLS + c;
            localparam int c_WEST = (c + COLS - 1) % COLS;
            localparam int c_EAST = (c + 1) % COLS;

            logic [W-1:0] w_north;
            logic [W-1:0] w_south;

            if (r == 0) begin : g_north_edge
                assign w_north = bus.din;
            end else begin : g_north_inner
                assign w_north = w_q[r-1][c];
            end

            if (r == ROWS - 1) begin : g_south_edge
                assign w_south = bus.din;
            end else begin : g_south_inner
                assign w_south = w_q[r+1][c];
            end

            muxpga_cell #(
                .W (W)
            ) u_cell (
                .clk       (clk),
                .reset     (reset),
                .i_en      (w_step_en),
                .i_north   (w_north),
                .i_south   (w_south),
                .i_west    (w_q[r][c_WEST]),
                .i_east    (w_q[r][c_EAST]),
                .i_mux_cfg (r_chain[2*c_K]),
                .i_lut_cfg (r_chain[2*c_K+1]),
                .o_q       (w_q[r][c])
            );
        end
    end

    // Readback mux: array corners while stepping/holding or busy, else status
    always_comb begin
        bus.dout = '0;
        if (r_busy || (bus.cmd == CMD_STEP) || (bus.cmd == CMD_HOLD)) begin
            bus.dout = {w_q[ROWS-1][0], w_q[ROWS-1][COLS-1]};
        end else begin
            bus.dout = {r_chain[c_CHAIN_LEN-1],
                        {(2*W-CFG_W-2){1'b0}},
                        w_cfg_loaded,
                        r_busy};
        end
    end

    assign bus.busy = r_busy;

endmodule : muxpga_array
`default_nettype wire

// File: tb/tb_muxpga_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_muxpga_array
// Brief    : Directed self-checking bench for muxpga_array (4x3, W=4) with a
//            queue scoreboard of expected dout/busy values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muxpga_array;
    import muxpga_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    muxpga_if #(.W(4)) bus ();

    muxpga_array #(
        .ROWS (4),
        .COLS (3),
        .W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q [$];
    string       tag_q [$];

    task automatic expect_val(input string tag, input logic [15:0] val);
        exp_q.push_back(val);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [15:0] obs);
        logic [15:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", t, obs, e);
        end
    endtask

    // One clock with the given inputs; outputs settle #1 after the edge
    task automatic drive(input cmd_e c, input logic [3:0] d);
        bus.cmd = c;
        bus.din = d;
        @(posedge clk);
        #1;
    endtask

    // Clock once, then compare dout and busy against the queued expectations
    task automatic step_chk(input cmd_e c, input logic [3:0] d, input string tag,
                            input logic [7:0] e_dout, input logic e_busy);
        expect_val({tag, "_dout"}, {8'h00, e_dout});
        expect_val({tag, "_busy"}, {15'h0, e_busy});
        drive(c, d);
        compare({8'h00, bus.dout});
        compare({15'h0, bus.busy});
    endtask

    // Change cmd without a clock edge to look at the combinational readback
    task automatic peek(input cmd_e c, input string tag,
                        input logic [7:0] e_dout, input logic e_busy);
        expect_val({tag, "_dout"}, {8'h00, e_dout});
        expect_val({tag, "_busy"}, {15'h0, e_busy});
        bus.cmd = c;
        #1;
        compare({8'h00, bus.dout});
        compare({15'h0, bus.busy});
    endtask

    // Full 24-nibble load; every cell pass-in1 from north, optionally cell
    // (3,0) reprogrammed to XOR of west (in1) and north (in2)
    task automatic load_cfg(input bit xor_cell);
        for (int j = 1; j <= 24; j++) begin
            logic [3:0] nib;
            nib = (j % 2 == 1) ? LUT_PASS1 : {SEL_N, SEL_N};
            if (xor_cell && j == 5) nib = LUT_XOR;
            if (xor_cell && j == 6) nib = {SEL_N, SEL_W};
            drive(CMD_SHIFT, nib);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        bus.cmd = CMD_HOLD;
        bus.din = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        peek(CMD_HOLD,  "reset_q",   8'h00, 1'b0);
        peek(CMD_SHIFT, "reset_cfg", 8'h00, 1'b0);

        // Load 0xC,0x0 x12: not loaded after 23, loaded after 24, then saturate
        for (int j = 1; j <= 23; j++) begin
            drive(CMD_SHIFT, (j % 2 == 1) ? 4'hC : 4'h0);
        end
        peek(CMD_SHIFT, "load_23", 8'h00, 1'b0);
        step_chk(CMD_SHIFT, 4'h0, "load_24", 8'hC2, 1'b0);
        step_chk(CMD_SHIFT, 4'hC, "shift_25_sat", 8'h02, 1'b0);
        load_cfg(1'b0);
        peek(CMD_SHIFT, "reload", 8'hC2, 1'b0);

        // Pass-in1 pipeline: din reaches the bottom row on the 4th step
        step_chk(CMD_STEP, 4'hA, "pipe_1", 8'h00, 1'b0);
        step_chk(CMD_STEP, 4'hA, "pipe_2", 8'h00, 1'b0);
        step_chk(CMD_STEP, 4'hA, "pipe_3", 8'h00, 1'b0);
        step_chk(CMD_STEP, 4'hA, "pipe_4", 8'hAA, 1'b0);
        step_chk(CMD_HOLD, 4'h5, "hold",   8'hAA, 1'b0);

        // Pre-state row2=3, row3=5 then XOR cell (3,0) = q(3,2)^q(2,0)
        drive(CMD_STEP, 4'h5);
        drive(CMD_STEP, 4'h3);
        drive(CMD_STEP, 4'h0);
        step_chk(CMD_STEP, 4'h0, "xor_pre", 8'h55, 1'b0);
        load_cfg(1'b1);
        peek(CMD_SHIFT, "xor_cfg", 8'hC2, 1'b0);
        step_chk(CMD_STEP, 4'h9, "xor_step", 8'h63, 1'b0);

        // Back to uniform pass-north and flush the array to zero
        load_cfg(1'b0);
        repeat (4) drive(CMD_STEP, 4'h0);
        peek(CMD_HOLD, "flushed", 8'h00, 1'b0);

        // RUN 3: busy for 3 cycles, commands during busy ignored
        step_chk(CMD_RUN,   4'h3, "run_start", 8'h00, 1'b1);
        step_chk(CMD_SHIFT, 4'h7, "run_c1",    8'h00, 1'b1);
        step_chk(CMD_STEP,  4'h7, "run_c2",    8'h00, 1'b1);
        step_chk(CMD_RUN,   4'h7, "run_c3",    8'hC2, 1'b0);
        step_chk(CMD_HOLD,  4'h7, "run_hold",  8'h00, 1'b0);
        step_chk(CMD_STEP,  4'h7, "run_plus1", 8'h77, 1'b0);

        // RUN 15 interrupted by reset
        step_chk(CMD_RUN, 4'hF, "run2_start", 8'h77, 1'b1);
        drive(CMD_HOLD, 4'h5);
        drive(CMD_HOLD, 4'h5);
        drive(CMD_HOLD, 4'h5);
        step_chk(CMD_HOLD, 4'h5, "run2_c4", 8'h55, 1'b1);
        reset = 1'b1;
        step_chk(CMD_HOLD, 4'h5, "reset_mid_run", 8'h00, 1'b0);
        reset = 1'b0;
        peek(CMD_SHIFT, "reset_cfg_clear", 8'h00, 1'b0);

        // RUN with count 0 never raises busy
        step_chk(CMD_RUN,  4'h0, "run_zero",       8'h00, 1'b0);
        step_chk(CMD_HOLD, 4'h0, "run_zero_after", 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_muxpga_array
`default_nettype wire
